// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel types and constants shared by hosts and devices
package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;
  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;
  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;
  parameter tl_a_user_t TL_A_USER_DEFAULT = '{instr_type: 4'h9, cmd_intg: 7'h0, data_intg: 7'h0};
  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/uart_tlul_bridge.sv
// uart_tlul_bridge: byte-stream 'W'/'R' command frames to single-word TL-UL accesses with status/data reply bytes
module uart_tlul_bridge
  import tlul_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1_250_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output tl_h2d_t    tl_o,
  input  tl_d2h_t    tl_i
);
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TLAST = TW'(TimeoutCycles - 1);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, RESP, REPLY} state_e;
  state_e state, state_d;
  logic is_wr;
  logic [1:0] cnt;
  logic [31:0] addr, data;
  logic [39:0] reply;
  logic [2:0] len;
  logic [TW-1:0] timer;
  logic in_frame, rx_fire, tx_fire, a_valid, a_fire, timeout, unused;
  assign in_frame = state inside {ADDR, DATA};
  assign rx_ready_o = !rst_i && (state == IDLE || in_frame);
  assign tx_valid_o = !rst_i && state == REPLY;
  assign tx_data_o = tx_valid_o ? reply[7:0] : 8'h00;
  assign a_valid = !rst_i && state == REQ;
  assign rx_fire = rx_valid_i && rx_ready_o;
  assign tx_fire = tx_valid_o && tx_ready_i;
  assign a_fire = a_valid && tl_i.a_ready;
  assign timeout = in_frame && !rx_fire && timer == TLAST;
  assign unused = ^tl_i;
  always_comb begin
    tl_o = '0;
    tl_o.a_user = TL_A_USER_DEFAULT;
    tl_o.d_ready = 1'b1;
    if (a_valid) begin
      tl_o.a_valid = 1'b1;
      tl_o.a_opcode = is_wr ? PutFullData : Get;
      tl_o.a_size = 2'd2;
      tl_o.a_mask = 4'hF;
      tl_o.a_address = addr;
      tl_o.a_data = is_wr ? data : 32'h0;
    end
  end
  // when the 4th address byte arrives, the first one (holding addr[1:0]) sits at addr[15:8]
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (rx_fire) state_d = (rx_data_i == 8'h57 || rx_data_i == 8'h52) ? ADDR : REPLY;
      ADDR:  if (rx_fire && cnt == 2'd3) state_d = addr[9:8] != 2'b00 ? REPLY : is_wr ? DATA : REQ;
             else if (timeout) state_d = IDLE;
      DATA:  if (rx_fire && cnt == 2'd3) state_d = REQ;
             else if (timeout) state_d = IDLE;
      REQ:   if (a_fire) state_d = RESP;
      RESP:  if (tl_i.d_valid) state_d = REPLY;
      REPLY: if (tx_fire && len == 3'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      is_wr <= 1'b0;
      cnt <= 2'd0;
      addr <= 32'h0;
      data <= 32'h0;
      reply <= 40'h0;
      len <= 3'd0;
      timer <= '0;
    end else begin
      state <= state_d;
      cnt <= state == IDLE ? 2'd0 : cnt + {1'b0, rx_fire};
      timer <= in_frame && !rx_fire && !timeout ? timer + 1'b1 : '0;
      if (rx_fire && state == IDLE) begin
        is_wr <= rx_data_i == 8'h57;
        reply <= 40'h3F;
        len <= 3'd1;
      end
      if (rx_fire && state == ADDR) begin
        addr <= {rx_data_i, addr[31:8]};
        reply <= 40'h15;
        len <= 3'd1;
      end
      if (rx_fire && state == DATA) data <= {rx_data_i, data[31:8]};
      if (state == RESP && tl_i.d_valid) begin
        reply <= tl_i.d_error ? 40'h15 : is_wr ? 40'h06 : {tl_i.d_data, 8'h06};
        len <= tl_i.d_error || is_wr ? 3'd1 : 3'd5;
      end
      if (tx_fire) begin
        reply <= {8'h00, reply[39:8]};
        len <= len - 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tlul_bridge.sv
// tb_uart_tlul_bridge: vector table, hand-written corner sequences and random frames against a frame-level model
module tb_uart_tlul_bridge;
  import tlul_pkg::*;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0;
  logic rx_valid = 0, rx_ready, tx_valid, tx_ready = 0;
  logic [7:0] tx_data;
  tl_h2d_t tl_o, rst_exp;
  tl_d2h_t tl_i;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  uart_tlul_bridge #(.TimeoutCycles(16)) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tl_o(tl_o), .tl_i(tl_i)
  );
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] size;
    logic [3:0] mask;
    logic [7:0] src;
    logic [31:0] addr;
    logic [31:0] data;
  } arec_t;
  typedef struct {
    logic [71:0] frame;
    int n;
    int gap;
    bit bus;
    bit derr;
    logic [31:0] ddata;
    int astall;
    arec_t a;
    logic [39:0] rep;
    int rn;
    int txstall;
  } vec_t;
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  arec_t a_cur, a_prev, a_last;
  bit a_pend = 0, t_pend = 0;
  logic [7:0] t_prev;
  int a_cnt = 0, av_cnt = 0;
  logic [7:0] tx_q[$];
  always @(negedge clk) begin
    a_cur.op = tl_o.a_opcode;
    a_cur.size = tl_o.a_size;
    a_cur.mask = tl_o.a_mask;
    a_cur.src = tl_o.a_source;
    a_cur.addr = tl_o.a_address;
    a_cur.data = tl_o.a_data;
    if (tl_o.a_valid) av_cnt++;
    if (a_pend && tl_o.a_valid) chk("a_stable", 128'(a_cur), 128'(a_prev));
    if (tl_o.a_valid && tl_i.a_ready) begin
      a_cnt++;
      a_last = a_cur;
    end
    a_pend = tl_o.a_valid && !tl_i.a_ready;
    a_prev = a_cur;
    if (t_pend && tx_valid) chk("tx_stable", 128'(tx_data), 128'(t_prev));
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    t_pend = tx_valid && !tx_ready;
    t_prev = tx_data;
  end
  task automatic send_byte(logic [7:0] b, int gap);
    bit got;
    int k;
    repeat (gap) tick;
    rx_data = b;
    rx_valid = 1;
    got = 0;
    k = 0;
    while (!got && k < 64) begin
      @(negedge clk);
      got = rx_ready;
      tick;
      k++;
    end
    rx_valid = 0;
    chk("rx_accept", 128'(got), 128'(1));
  endtask
  task automatic serve_bus(int astall, bit derr, logic [31:0] dd);
    int k;
    k = 0;
    @(negedge clk);
    chk("a_latency", 128'(tl_o.a_valid), 128'(1));
    while (!tl_o.a_valid && k < 20) begin
      tick;
      @(negedge clk);
      k++;
    end
    if (!tl_o.a_valid) return;
    tick;
    repeat (astall) tick;
    tl_i.a_ready = 1;
    @(negedge clk);
    tick;
    tl_i.a_ready = 0;
    tl_i.d_valid = 1;
    tl_i.d_error = derr;
    tl_i.d_data = dd;
    tick;
    tl_i.d_valid = 0;
    tl_i.d_error = 0;
    tl_i.d_data = 0;
  endtask
  task automatic collect_reply(int n, int stall);
    bit got;
    int k;
    for (int i = 0; i < n; i++) begin
      got = 0;
      k = 0;
      repeat (stall) tick;
      tx_ready = 1;
      while (!got && k < 64) begin
        @(negedge clk);
        got = tx_valid;
        tick;
        k++;
      end
      tx_ready = 0;
      chk("tx_wait", 128'(got), 128'(1));
    end
  endtask
  task automatic run_vec(vec_t v, string tag);
    int a0, v0;
    a0 = a_cnt;
    v0 = av_cnt;
    tx_q.delete();
    for (int i = 0; i < v.n; i++) send_byte(v.frame[8*i +: 8], v.gap);
    if (v.bus) serve_bus(v.astall, v.derr, v.ddata);
    collect_reply(v.rn, v.txstall);
    chk({tag, "_a_count"}, 128'(a_cnt - a0), 128'(v.bus ? 1 : 0));
    if (v.bus) chk({tag, "_a_fields"}, 128'(a_last), 128'(v.a));
    else chk({tag, "_no_a_valid"}, 128'(av_cnt - v0), 128'(0));
    chk({tag, "_rep_len"}, 128'(tx_q.size()), 128'(v.rn));
    for (int i = 0; i < v.rn && i < tx_q.size(); i++)
      chk($sformatf("%s_rep%0d", tag, i), 128'(tx_q[i]), 128'(v.rep[8*i +: 8]));
    @(negedge clk);
    chk({tag, "_idle"}, 128'(rx_ready), 128'(1));
    tick;
  endtask
  function automatic vec_t mkv(logic [71:0] frame, int n, bit bus, bit derr, logic [31:0] dd, int astall,
                               logic [2:0] op, logic [31:0] addr, logic [31:0] wdata, logic [39:0] rep, int rn, int txstall);
    vec_t v;
    v.frame = frame;
    v.n = n;
    v.gap = 0;
    v.bus = bus;
    v.derr = derr;
    v.ddata = dd;
    v.astall = astall;
    v.a = '{op: op, size: 2'd2, mask: 4'hF, src: 8'h0, addr: addr, data: wdata};
    v.rep = rep;
    v.rn = rn;
    v.txstall = txstall;
    return v;
  endfunction
  function automatic vec_t rand_vec();
    int kind;
    bit wr, derr;
    logic [31:0] addr, wd, dd;
    logic [7:0] b;
    vec_t v;
    kind = $urandom_range(0, 9);
    wr = kind <= 5;
    addr = $urandom;
    if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
    wd = $urandom;
    dd = $urandom;
    derr = $urandom_range(0, 4) == 0;
    b = 8'($urandom_range(0, 255));
    if (b == 8'h57 || b == 8'h52) b = 8'h00;
    if (kind == 0) v = mkv({64'h0, b}, 1, 0, 0, 0, 0, 0, 0, 0, 40'h3F, 1, 0);
    else if (addr[1:0] != 2'b00) v = mkv(wr ? {wd, addr, 8'h57} : {32'h0, addr, 8'h52}, 5, 0, 0, 0, 0, 0, 0, 0, 40'h15, 1, 0);
    else v = mkv(wr ? {wd, addr, 8'h57} : {32'h0, addr, 8'h52}, wr ? 9 : 5, 1, derr, dd, 0,
                 wr ? 3'd0 : 3'd4, addr, wr ? wd : 32'h0,
                 derr ? 40'h15 : wr ? 40'h06 : {dd, 8'h06}, (derr || wr) ? 1 : 5, 0);
    v.gap = $urandom_range(0, 4);
    v.astall = $urandom_range(0, 3);
    v.txstall = $urandom_range(0, 2);
    return v;
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    vec_t vt[8];
    vec_t v;
    int a0, v0;
    tl_i = '0;
    rst_exp = '0;
    rst_exp.a_user = TL_A_USER_DEFAULT;
    rst_exp.d_ready = 1'b1;
    vt[0] = mkv(72'hDEADBEEF_00010000_57, 9, 1, 0, 32'h0, 0, 3'd0, 32'h00010000, 32'hDEADBEEF, 40'h06, 1, 0);
    vt[1] = mkv(72'h00010000_52, 5, 1, 0, 32'hDEADBEEF, 0, 3'd4, 32'h00010000, 32'h0, 40'hDEADBEEF_06, 5, 3);
    vt[2] = mkv(72'h00020040_52, 5, 1, 1, 32'h12345678, 5, 3'd4, 32'h00020040, 32'h0, 40'h15, 1, 1);
    vt[3] = mkv(72'h00000002_52, 5, 0, 0, 32'h0, 0, 3'd0, 32'h0, 32'h0, 40'h15, 1, 0);
    vt[4] = mkv(72'h41, 1, 0, 0, 32'h0, 0, 3'd0, 32'h0, 32'h0, 40'h3F, 1, 0);
    vt[5] = mkv(72'hCAFEF00D_80000004_57, 9, 1, 1, 32'h0, 2, 3'd0, 32'h80000004, 32'hCAFEF00D, 40'h15, 1, 0);
    vt[6] = mkv(72'h80000003_57, 5, 0, 0, 32'h0, 0, 3'd0, 32'h0, 32'h0, 40'h15, 1, 0);
    vt[7] = mkv(72'h00000000_FFFFFFFC_57, 9, 1, 0, 32'h0, 1, 3'd0, 32'hFFFFFFFC, 32'h0, 40'h06, 1, 2);
    repeat (3) tick;
    @(negedge clk);
    chk("reset_tl", 128'(tl_o), 128'(rst_exp));
    chk("reset_rx_ready", 128'(rx_ready), 128'(0));
    chk("reset_tx_valid", 128'(tx_valid), 128'(0));
    chk("reset_tx_data", 128'(tx_data), 128'(0));
    tick;
    rst = 0;
    @(negedge clk);
    chk("idle_rx_ready", 128'(rx_ready), 128'(1));
    tick;
    tl_i.d_valid = 1;
    tl_i.d_error = 1;
    repeat (3) tick;
    tl_i.d_valid = 0;
    tl_i.d_error = 0;
    @(negedge clk);
    chk("stray_d_tx", 128'(tx_valid), 128'(0));
    chk("stray_d_rx", 128'(rx_ready), 128'(1));
    tick;
    for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));
    tx_q.delete();
    send_byte(8'h41, 0);
    rx_data = 8'h52;
    rx_valid = 1;
    @(negedge clk);
    chk("bp_rx_ready", 128'(rx_ready), 128'(0));
    tick;
    tick;
    collect_reply(1, 0);
    @(negedge clk);
    chk("bp_accept", 128'(rx_ready), 128'(1));
    tick;
    rx_valid = 0;
    for (int i = 0; i < 4; i++) send_byte(i == 2 ? 8'h01 : 8'h00, 0);
    serve_bus(0, 0, 32'hA5A50001);
    collect_reply(5, 0);
    chk("bp_rep_len", 128'(tx_q.size()), 128'(6));
    if (tx_q.size() == 6) begin
      chk("bp_rep0", 128'(tx_q[0]), 128'(8'h3F));
      chk("bp_rep1", 128'(tx_q[1]), 128'(8'h06));
      chk("bp_rep5", 128'(tx_q[5]), 128'(8'hA5));
    end
    chk("bp_a_addr", 128'(a_last.addr), 128'(32'h00010000));
    a0 = a_cnt;
    v0 = av_cnt;
    tx_q.delete();
    send_byte(8'h57, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    repeat (16) tick;
    @(negedge clk);
    chk("to_no_tx", 128'(tx_valid), 128'(0));
    chk("to_no_a", 128'(av_cnt - v0), 128'(0));
    tick;
    v = vt[1];
    v.ddata = 32'h12345678;
    v.rep = 40'h12345678_06;
    v.txstall = 0;
    run_vec(v, "to_flush");
    send_byte(8'h57, 0);
    repeat (15) tick;
    v = vt[0];
    v.frame = v.frame >> 8;
    v.n = 8;
    run_vec(v, "to_edge");
    a0 = a_cnt;
    for (int i = 0; i < 5; i++) send_byte(vt[1].frame[8*i +: 8], 0);
    @(negedge clk);
    chk("rst_req_valid", 128'(tl_o.a_valid), 128'(1));
    tick;
    tick;
    rst = 1;
    tick;
    chk("rst_req_drop", 128'(tl_o.a_valid), 128'(0));
    chk("rst_req_tl", 128'(tl_o), 128'(rst_exp));
    chk("rst_req_rx", 128'(rx_ready), 128'(0));
    rst = 0;
    @(negedge clk);
    chk("rst_req_rx_after", 128'(rx_ready), 128'(1));
    chk("rst_req_no_hs", 128'(a_cnt - a0), 128'(0));
    tick;
    run_vec(vt[0], "post_rst");
    for (int i = 0; i < 40; i++) run_vec(rand_vec(), $sformatf("rnd%0d", i));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
